// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Handshaked EX-stage execution unit. Decodes ALUOp/OpCode/funct7/
//            funct3 internally, executes base integer ops in one cycle,
//            MUL* in two cycles and DIV*/REM* with an iterative radix-2
//            restoring divider. The result is held until the consumer
//            accepts it.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_valid/in_ready   - request handshake (in_ready = unit idle)
//            ALUOp, OpCode,
//            funct7, funct3      - undecoded instruction control fields
//            op_a, op_b          - XLEN-bit operands
//            out_valid/out_ready - result handshake
//            result, zero,
//            illegal             - result, result==0, unsupported encoding
//            busy                - a MUL or DIV is in flight
// Options  : ALU_EXEC_MEXT_EN - when defined, the M extension (multiplier and
//            divider) is built; otherwise M encodings decode as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      OpCode,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_exec    = 3'd1;
   localparam logic [2:0] c_st_done    = 3'd2;
`ifdef ALU_EXEC_MEXT_EN
   localparam logic [2:0] c_st_mul1    = 3'd3;
   localparam logic [2:0] c_st_div     = 3'd4;
   localparam logic [2:0] c_st_div_fix = 3'd5;
`endif

   // Internal op encoding: base ops 0..7 share the funct3 numbering,
   // M ops 8..15 are {2'b01, funct3}, so decode is mostly concatenation.
   localparam logic [4:0] c_op_add  = 5'd0;
   localparam logic [4:0] c_op_sll  = 5'd1;
   localparam logic [4:0] c_op_slt  = 5'd2;
   localparam logic [4:0] c_op_sltu = 5'd3;
   localparam logic [4:0] c_op_xor  = 5'd4;
   localparam logic [4:0] c_op_srl  = 5'd5;
   localparam logic [4:0] c_op_or   = 5'd6;
   localparam logic [4:0] c_op_and  = 5'd7;
   localparam logic [4:0] c_op_sub  = 5'd16;
   localparam logic [4:0] c_op_sra  = 5'd17;
   localparam logic [4:0] c_op_ill  = 5'd31;
`ifdef ALU_EXEC_MEXT_EN
   localparam logic [4:0] c_op_mul    = 5'd8;
   localparam logic [4:0] c_op_mulh   = 5'd9;
   localparam logic [4:0] c_op_mulhsu = 5'd10;
   localparam logic [4:0] c_op_div    = 5'd12;
   localparam logic [4:0] c_op_divu   = 5'd13;
   localparam logic [4:0] c_op_rem    = 5'd14;
   localparam logic [4:0] c_op_remu   = 5'd15;

   localparam int              CNT_W      = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN);
   localparam logic [XLEN-1:0]  c_most_neg = {1'b1, {(XLEN-1){1'b0}}};
`endif

   logic [2:0]      state_q, state_d;
   logic [4:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;

   logic [4:0]      w_op;
   logic [2:0]      w_next_state;
   logic [XLEN-1:0] w_alu;

`ifdef ALU_EXEC_MEXT_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;

   logic              w_mul_sa, w_mul_sb;
   logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
   logic              w_div_signed, w_is_rem;
   logic [XLEN:0]     w_rem_sh, w_diff;
   logic [XLEN-1:0]   w_quo_fix, w_rem_fix;
`endif

   // ------------------------------------------------------------------
   // Instruction decode (from the live inputs, captured on accept)
   // ------------------------------------------------------------------
   always_comb begin
      w_op = c_op_ill;
      case (ALUOp)
         2'b00: w_op = c_op_add;
         2'b01: w_op = c_op_sub;
         2'b10: begin
            if (OpCode == 7'b0110011) begin
               case (funct7)
                  7'b0000000: w_op = {2'b00, funct3};
                  7'b0100000: begin
                     if (funct3 == 3'b000)      w_op = c_op_sub;
                     else if (funct3 == 3'b101) w_op = c_op_sra;
                     else                       w_op = c_op_ill;
                  end
`ifdef ALU_EXEC_MEXT_EN
                  7'b0000001: w_op = {2'b01, funct3};
`endif
                  default:    w_op = c_op_ill;
               endcase
            end else begin
               // I-type: funct7[5] only distinguishes srai from srli
               if (funct3 == 3'b101 && funct7[5]) w_op = c_op_sra;
               else                               w_op = {2'b00, funct3};
            end
         end
         default: w_op = c_op_ill;
      endcase
   end

   // Where an accepted request goes. Divide-by-zero and signed overflow
   // have fixed answers and skip the iterative divider.
   always_comb begin
      w_next_state = c_st_exec;
`ifdef ALU_EXEC_MEXT_EN
      if (w_op[4:2] == 3'b010) begin
         w_next_state = c_st_mul1;
      end else if (w_op[4:2] == 3'b011 && op_b != '0 &&
                   !(!w_op[0] && op_a == c_most_neg && op_b == '1)) begin
         w_next_state = c_st_div;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Single-cycle datapath (also produces the divider fast-path answers)
   // ------------------------------------------------------------------
   always_comb begin
      w_alu = '0;
      case (op_q)
         c_op_add:  w_alu = a_q + b_q;
         c_op_sub:  w_alu = a_q - b_q;
         c_op_sll:  w_alu = a_q << b_q[SH_W-1:0];
         c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, a_q < b_q};
         c_op_xor:  w_alu = a_q ^ b_q;
         c_op_srl:  w_alu = a_q >> b_q[SH_W-1:0];
         c_op_sra:  w_alu = $signed(a_q) >>> b_q[SH_W-1:0];
         c_op_or:   w_alu = a_q | b_q;
         c_op_and:  w_alu = a_q & b_q;
`ifdef ALU_EXEC_MEXT_EN
         c_op_div:  w_alu = (b_q == '0) ? '1 : c_most_neg;
         c_op_divu: w_alu = '1;
         c_op_rem:  w_alu = (b_q == '0) ? a_q : '0;
         c_op_remu: w_alu = a_q;
`endif
         default:   w_alu = '0;
      endcase
   end

`ifdef ALU_EXEC_MEXT_EN
   // ------------------------------------------------------------------
   // Multiplier: operands sign- or zero-extended to 2*XLEN so one
   // unsigned multiply yields the correct high half for every variant.
   // ------------------------------------------------------------------
   always_comb begin
      w_mul_sa = (op_q == c_op_mulh) || (op_q == c_op_mulhsu);
      w_mul_sb = (op_q == c_op_mulh);
      w_mul_a  = {{XLEN{w_mul_sa & a_q[XLEN-1]}}, a_q};
      w_mul_b  = {{XLEN{w_mul_sb & b_q[XLEN-1]}}, b_q};
      w_prod   = w_mul_a * w_mul_b;
   end

   // ------------------------------------------------------------------
   // Divider: restoring radix-2 on magnitudes; signs applied in DIV_FIX.
   // The partial remainder never exceeds the divisor, so the shifted value
   // needs one extra bit and the top bit of the difference is the borrow.
   // ------------------------------------------------------------------
   always_comb begin
      w_div_signed = !op_q[0];
      w_is_rem     = op_q[1];
      w_rem_sh     = {rem_q, quo_q[XLEN-1]};
      w_diff       = w_rem_sh - {1'b0, dvs_q};
      w_quo_fix    = (w_div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
      w_rem_fix    = (w_div_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
   end
`endif

   // ------------------------------------------------------------------
   // Control FSM and register next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_EXEC_MEXT_EN
      cnt_d  = cnt_q;
      prod_d = prod_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
`endif
      case (state_q)
         c_st_idle: begin
            if (in_valid) begin
               op_d    = w_op;
               a_d     = op_a;
               b_d     = op_b;
               state_d = w_next_state;
`ifdef ALU_EXEC_MEXT_EN
               cnt_d   = '0;
`endif
            end
         end
         c_st_exec: begin
            result_d  = w_alu;
            zero_d    = (w_alu == '0);
            illegal_d = (op_q == c_op_ill);
            state_d   = c_st_done;
         end
`ifdef ALU_EXEC_MEXT_EN
         c_st_mul1: begin
            // Cycle 0 registers the full product, cycle 1 selects the half.
            if (cnt_q == '0) begin
               prod_d = w_prod;
               cnt_d  = cnt_q + 1'b1;
            end else begin
               result_d  = (op_q == c_op_mul) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
               zero_d    = (result_d == '0);
               illegal_d = 1'b0;
               state_d   = c_st_done;
            end
         end
         c_st_div: begin
            if (cnt_q == '0) begin
               // Setup cycle: load magnitudes.
               quo_d = (w_div_signed && a_q[XLEN-1]) ? -a_q : a_q;
               dvs_d = (w_div_signed && b_q[XLEN-1]) ? -b_q : b_q;
               rem_d = '0;
            end else if (!w_diff[XLEN]) begin
               rem_d = w_diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = w_rem_sh[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_cnt_last) begin
               state_d = c_st_div_fix;
            end
         end
         c_st_div_fix: begin
            result_d  = w_is_rem ? w_rem_fix : w_quo_fix;
            zero_d    = (result_d == '0);
            illegal_d = 1'b0;
            state_d   = c_st_done;
         end
`endif
         c_st_done: begin
            if (out_ready) begin
               state_d = c_st_idle;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= c_st_idle;
         op_q      <= c_op_ill;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_EXEC_MEXT_EN
         cnt_q  <= '0;
         prod_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifdef ALU_EXEC_MEXT_EN
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
`endif
      end
   end

   assign in_ready  = (state_q == c_st_idle);
   assign out_valid = (state_q == c_st_done);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
`ifdef ALU_EXEC_MEXT_EN
   assign busy = (state_q == c_st_mul1) || (state_q == c_st_div) ||
                 (state_q == c_st_div_fix);
`else
   assign busy = 1'b0;
`endif

endmodule
`default_nettype wire
